// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmitter with integrated FIFO.
//
// Contents:
//   parity_e       parity selection encoding (matches the parity_mode port)
//   tx_state_e     transmitter FSM states
//   MIN_DIV        smallest usable baud divisor; smaller values are clamped
//   parity_enabled helper telling whether a parity bit is inserted
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // A divisor of at least two guarantees the stop bit has a cycle before its
  // last one, which is where the registered frame_done pulse is set up.
  localparam int MIN_DIV = 2;

  // The reserved encoding behaves like "no parity".
  function automatic logic parity_enabled(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock registered FIFO used as the transmit queue. No fall-through: a
// word written in one cycle is visible at the head from the next cycle on.
// full and empty come straight from the registered count, so a pop while full
// only frees space (full drops) in the following cycle.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   push        write request; ignored while full
//   push_data   word to write
//   pop         read request; ignored while empty
//   pop_data    current head word (valid when !empty)
//   count       number of stored words, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits wide, so incrementing past the last
  // entry wraps to zero on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with an integrated transmit FIFO. Words are queued over a
// valid/ready handshake and sent as: start bit, DATA_W data bits LSB first,
// optional parity bit, one or two stop bits. While words remain queued and
// tx_en is high, frames follow each other with no idle gap.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   baud_div      clock cycles per bit (values below 2 act as 2)
//   parity_mode   0 none, 1 even, 2 odd, 3 none
//   two_stop      1 selects two stop bits
//   tx_en         permits new frames to start
//   wr_valid      write request
//   wr_data       word to queue
//   wr_ready      FIFO has space
//   tx_out        serial line, idle high
//   tx_busy       a frame is in progress
//   fifo_count    words currently queued
//   frame_done    one-cycle pulse during the last cycle of the final stop bit
//
// baud_div, parity_mode and two_stop are captured when a word is popped, so
// changing them mid-frame only affects the next frame.
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIV_W-1:0]        baud_div,
  input  logic [1:0]              parity_mode,
  input  logic                    two_stop,
  input  logic                    tx_en,
  input  logic                    wr_valid,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  output logic                    tx_out,
  output logic                    tx_busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    frame_done
);

  localparam int BW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  parity_e           par_mode_q, par_mode_d;
  logic              two_stop_q, two_stop_d;
  logic              tx_out_q, tx_out_d;
  logic              frame_done_q, frame_done_d;

  logic [DIV_W-1:0]  div_eff;
  logic              bit_end;
  logic              can_start;
  logic              start_frame;
  logic              final_stop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready   = !fifo_full;
  assign tx_out     = tx_out_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = frame_done_q;

  assign div_eff    = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  // The baud counter counts down from divisor-1; zero marks a bit's last cycle.
  assign bit_end    = (baud_cnt_q == '0);
  assign can_start  = tx_en && !fifo_empty;
  assign final_stop = !two_stop_q || (bit_cnt_q == BW'(1));

  // Next-state logic. tx_out is registered, so each transition sets the line
  // level for the bit that begins in the following cycle. Starting a frame is
  // shared by IDLE and the end of the last stop bit (back-to-back frames).
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    par_mode_d   = par_mode_q;
    two_stop_d   = two_stop_q;
    tx_out_d     = tx_out_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    start_frame  = 1'b0;

    if (state_q == IDLE) begin
      baud_cnt_d = baud_cnt_q;
    end else if (bit_end) begin
      baud_cnt_d = div_q - DIV_W'(1);
    end else begin
      baud_cnt_d = baud_cnt_q - DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (can_start) begin
          start_frame = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          tx_out_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            if (parity_enabled(par_mode_q)) begin
              state_d  = PARITY;
              tx_out_d = par_bit_q;
            end else begin
              state_d   = STOP;
              tx_out_d  = 1'b1;
              bit_cnt_d = '0;
            end
          end else begin
            tx_out_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          tx_out_d  = 1'b1;
          bit_cnt_d = '0;
        end
      end

      STOP: begin
        if (!bit_end) begin
          // Set up the pulse one cycle early so it lands on the final cycle.
          if (final_stop && (baud_cnt_q == DIV_W'(1))) begin
            frame_done_d = 1'b1;
          end
        end else if (final_stop) begin
          if (can_start) begin
            start_frame = 1'b1;
          end else begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
      end
    endcase

    // Pop the head word and capture the frame configuration together, so the
    // whole frame uses one consistent divisor, parity and stop setting.
    if (start_frame) begin
      fifo_pop   = 1'b1;
      state_d    = START;
      tx_out_d   = 1'b0;
      shift_d    = fifo_head;
      div_d      = div_eff;
      baud_cnt_d = div_eff - DIV_W'(1);
      par_mode_d = parity_e'(parity_mode);
      two_stop_d = two_stop;
      par_bit_d  = (^fifo_head) ^ (parity_e'(parity_mode) == PAR_ODD);
    end
  end

  // All FSM state and the registered outputs. Reset drives the line high at
  // once, even in the middle of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      div_q        <= DIV_W'(MIN_DIV);
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      par_mode_q   <= PAR_NONE;
      two_stop_q   <= 1'b0;
      tx_out_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      par_mode_q   <= par_mode_d;
      two_stop_q   <= two_stop_d;
      tx_out_q     <= tx_out_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO, runtime-programmable baud divisor, and configurable parity and stop bits. Upstream logic pushes words over a valid/ready handshake. The block serialises each word as start, data LSB-first, optional parity and 1 or 2 stop bits. Frames are sent back to back with no idle gap while data is queued and transmission is enabled.

Parameters:
DATA_W, 8, data bits per frame, legal range 5..9
DEPTH, 8, FIFO entries, power of two, minimum 2
DIV_W, 16, width of the baud divisor input

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
baud_div  in  DIV_W  clock cycles per bit
parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none
two_stop  in  1  1 = two stop bits, 0 = one
tx_en  in  1  allows new frames to start
wr_valid  in  1  write request
wr_data  in  DATA_W  write word
wr_ready  out  1  FIFO can accept a word
tx_out  out  1  serial line, idle high
tx_busy  out  1  frame in progress
fifo_count  out  $clog2(DEPTH)+1  entries queued
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values (asynchronous, rst=1): tx_out=1, tx_busy=0, wr_ready=1, fifo_count=0, frame_done=0; FSM=IDLE; FIFO empty.
- Write: a word is accepted when wr_valid && wr_ready. wr_ready = !full.
  - FIFO is registered, with no fall-through.
  - When full, a pop in the same cycle does not raise wr_ready until the next cycle.
  - A write while full is ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Condition to leave: tx_en && !empty.
  - Actions: pop the head word into the shift register; latch baud_div, parity_mode and two_stop; go to START.
  - Mid-frame changes to these config inputs have no effect.
- Effective divisor: max(baud_div, 2). A divisor of 0 or 1 is treated as 2.
- Bit timing: every bit holds tx_out for exactly the effective divisor in cycles. The baud counter reloads at each bit boundary.
- START: drive tx_out=0, then go to DATA.
- DATA: send DATA_W bits LSB-first. After the last bit, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: even mode sends XOR of the data bits; odd mode sends its inverse.
- STOP: send 1 or 2 stop bits (tx_out=1).
- Frame end:
  - frame_done pulses in the last cycle of the final stop bit.
  - In that same cycle, if tx_en && !empty, the next word is popped and the START bit begins the following cycle, giving zero idle gap.
  - Otherwise the FSM returns to IDLE.
- tx_busy: 1 in every state except IDLE.
- Frame length: (1 + DATA_W + P + S) × divisor cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Latency: push into an empty FIFO at cycle N with the FSM idle and tx_en=1 → pop at cycle N+1 → tx_out falls at cycle N+2.
- tx_en deasserted mid-frame: the current frame completes normally; no new frame starts.
- Simultaneous push and pop: fifo_count is unchanged; pointers wrap modulo DEPTH.
- rst mid-frame: line returns high immediately and FIFO contents are discarded.

Decomposition:
- Package uart_pkg holds:
  - enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD}
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparam MIN_DIV = 2
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds storage, pointers, count, full and empty.
- Top level holds the FSM, baud counter, bit counter and shift register.

Test Plan:
1. Parameters DATA_W=8, DEPTH=4; baud_div=4, parity even, one stop; push 0xA5 → tx_out sequence 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; frame_done pulses once at cycle 44 after the start edge.
2. Odd parity, two_stop=1, baud_div=4; push 0x01 → bits 0,1,0,0,0,0,0,0,0,0,1,1; frame is 48 cycles long.
3. tx_en=0; push 5 words → wr_ready low after the 4th, fifo_count=4, 5th write ignored; then set tx_en=1 → 4 frames with no idle cycles between them, fifo_count reaches 0, tx_busy falls after the 4th frame_done.
4. baud_div=0, parity none → each bit lasts 2 cycles; frame is 20 cycles long.
5. Assert rst during the DATA state of a frame with 2 words queued → tx_out=1 immediately, fifo_count=0, tx_busy=0; no frame after rst releases.
6. Change baud_div from 4 to 8 mid-frame → current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
